// File: rtl/urp_pcie_tx_vc_scheduler.sv
// PCIe TX transaction layer: builds 3DW-header TLPs, queues them per VC by TC and schedules
// them onto one registered output under per-VC credits. Define URP_PCIE_TX_VC_STRICT_PRIO_EN for strict-priority grant.
module urp_pcie_tx_vc_scheduler #(
    parameter  int unsigned N_VC        = 2,
    parameter  int unsigned DEPTH_LG2   = 4,
    parameter  int unsigned PAYLOAD_W   = 128,
    parameter  int unsigned CREDIT_W    = 4,
    parameter  int unsigned CREDIT_INIT = 8,
    localparam int unsigned TLP_W       = 96 + PAYLOAD_W,
    localparam int unsigned VC_W        = (N_VC > 1) ? $clog2(N_VC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [2:0]           req_fmt_i,
    input  logic [4:0]           req_type_i,
    input  logic [2:0]           req_tc_i,
    input  logic [9:0]           req_length_i,
    input  logic [15:0]          req_requester_id_i,
    input  logic [15:0]          req_completer_id_i,
    input  logic [31:0]          req_addr_i,
    input  logic [PAYLOAD_W-1:0] req_payload_i,
    input  logic [N_VC-1:0]      credit_ret_i,
    output logic [TLP_W-1:0]     tlp_o,
    output logic [VC_W-1:0]      tlp_vc_o,
    output logic                 tlp_valid_o,
    input  logic                 tlp_ready_i,
    output logic                 drop_o,
    output logic [N_VC-1:0]      vc_full_o
);

    localparam int unsigned DEPTH      = 1 << DEPTH_LG2;
    localparam int unsigned PTR_W      = DEPTH_LG2 + 1;
    localparam int unsigned VC_SHIFT   = 3 - $clog2(N_VC);
    localparam int unsigned CREDIT_MAX = (1 << CREDIT_W) - 1;

    logic [TLP_W-1:0]    mem [N_VC][DEPTH];
    logic [PTR_W-1:0]    wr_ptr [N_VC];
    logic [PTR_W-1:0]    rd_ptr [N_VC];
    logic [CREDIT_W-1:0] credit [N_VC];
`ifndef URP_PCIE_TX_VC_STRICT_PRIO_EN
    logic [VC_W-1:0]     rr_ptr;
`endif

    logic                is_mem;
    logic                is_cpl;
    logic                supported;
    logic [VC_W-1:0]     req_vc;
    logic [31:0]         dw0;
    logic [31:0]         dw1;
    logic [31:0]         dw2;
    logic                wr_en;
    logic [N_VC-1:0]     eligible;
    logic [VC_W-1:0]     grant;
    logic                load;
    logic [PTR_W-1:0]    fifo_cnt [N_VC];

    // Request decode and header build
    always_comb begin
        is_mem    = (req_type_i == 5'b00000) || (req_type_i == 5'b00001);
        is_cpl    = (req_type_i == 5'b01010);
        supported = is_mem || is_cpl;
        req_vc    = VC_W'(req_tc_i >> VC_SHIFT);
        dw0       = {req_fmt_i, req_type_i, req_tc_i, req_length_i, 11'b0};
        dw1       = is_cpl ? {req_completer_id_i, req_requester_id_i}
                           : {req_requester_id_i, 16'h0};
        dw2       = {req_addr_i[31:2], 2'b00};
    end

    // FIFO status and scheduling eligibility
    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            fifo_cnt[v]  = wr_ptr[v] - rd_ptr[v];
            vc_full_o[v] = (fifo_cnt[v] == PTR_W'(DEPTH));
            eligible[v]  = (fifo_cnt[v] != '0) && (credit[v] != '0);
        end
        req_ready_o = supported ? ~vc_full_o[req_vc] : 1'b1;
        wr_en       = req_valid_i && req_ready_o && supported;
    end

    // Grant selection
    always_comb begin
        grant = '0;
`ifdef URP_PCIE_TX_VC_STRICT_PRIO_EN
        for (int v = 0; v < N_VC; v++) begin
            if (eligible[v]) grant = VC_W'(v);
        end
`else
        // Walk downward so the candidate closest to rr_ptr is written last
        for (int k = N_VC - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr) + k) % N_VC]) grant = VC_W'((int'(rr_ptr) + k) % N_VC);
        end
`endif
        load = (~tlp_valid_o || tlp_ready_i) && (eligible != '0);
    end

    // FIFO storage (no reset needed; validity tracked by pointers)
    always_ff @(posedge clk) begin
        if (wr_en) mem[req_vc][wr_ptr[req_vc][DEPTH_LG2-1:0]] <= {dw0, dw1, dw2, req_payload_i};
    end

    // FIFO pointers and credit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < N_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                credit[v] <= CREDIT_W'(CREDIT_INIT);
            end
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (wr_en && (req_vc == VC_W'(v))) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
                if (load && (grant == VC_W'(v))) begin
                    rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
                    if (!credit_ret_i[v]) credit[v] <= credit[v] - CREDIT_W'(1);
                end else if (credit_ret_i[v] && (credit[v] != CREDIT_W'(CREDIT_MAX))) begin
                    credit[v] <= credit[v] + CREDIT_W'(1);
                end
            end
        end
    end

    // Output register, round-robin pointer and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlp_o       <= '0;
            tlp_vc_o    <= '0;
            tlp_valid_o <= 1'b0;
            drop_o      <= 1'b0;
`ifndef URP_PCIE_TX_VC_STRICT_PRIO_EN
            rr_ptr      <= '0;
`endif
        end else begin
            drop_o <= req_valid_i && !supported;
            if (load) begin
                tlp_o       <= mem[grant][rd_ptr[grant][DEPTH_LG2-1:0]];
                tlp_vc_o    <= grant;
                tlp_valid_o <= 1'b1;
`ifndef URP_PCIE_TX_VC_STRICT_PRIO_EN
                rr_ptr      <= VC_W'((int'(grant) + 1) % N_VC);
`endif
            end else if (tlp_ready_i) begin
                tlp_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_urp_pcie_tx_vc_scheduler.sv
// Self-checking bench for urp_pcie_tx_vc_scheduler: directed steps plus random traffic
// checked every cycle against a queue-based reference model.
module tb_urp_pcie_tx_vc_scheduler;

    localparam int unsigned N_VC        = 2;
    localparam int unsigned DEPTH_LG2   = 2;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned PAYLOAD_W   = 32;
    localparam int unsigned CREDIT_W    = 4;
    localparam int unsigned CREDIT_INIT = 2;
    localparam int unsigned CREDIT_MAX  = 15;
    localparam int unsigned TLP_W       = 96 + PAYLOAD_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [2:0]           req_fmt_i;
    logic [4:0]           req_type_i;
    logic [2:0]           req_tc_i;
    logic [9:0]           req_length_i;
    logic [15:0]          req_requester_id_i;
    logic [15:0]          req_completer_id_i;
    logic [31:0]          req_addr_i;
    logic [PAYLOAD_W-1:0] req_payload_i;
    logic [N_VC-1:0]      credit_ret_i;
    logic [TLP_W-1:0]     tlp_o;
    logic [0:0]           tlp_vc_o;
    logic                 tlp_valid_o;
    logic                 tlp_ready_i;
    logic                 drop_o;
    logic [N_VC-1:0]      vc_full_o;

    always #5 clk = ~clk;

    urp_pcie_tx_vc_scheduler #(
        .N_VC(N_VC), .DEPTH_LG2(DEPTH_LG2), .PAYLOAD_W(PAYLOAD_W),
        .CREDIT_W(CREDIT_W), .CREDIT_INIT(CREDIT_INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_fmt_i(req_fmt_i), .req_type_i(req_type_i), .req_tc_i(req_tc_i),
        .req_length_i(req_length_i), .req_requester_id_i(req_requester_id_i),
        .req_completer_id_i(req_completer_id_i), .req_addr_i(req_addr_i),
        .req_payload_i(req_payload_i), .credit_ret_i(credit_ret_i),
        .tlp_o(tlp_o), .tlp_vc_o(tlp_vc_o), .tlp_valid_o(tlp_valid_o),
        .tlp_ready_i(tlp_ready_i), .drop_o(drop_o), .vc_full_o(vc_full_o)
    );

    int ncmp = 0;
    int nmis = 0;
    int issued_vc1 = 0;

    // Reference model state
    logic [TLP_W-1:0] mq [N_VC][$];
    int               mcred [N_VC];
    int               mptr;
    bit               mvalid;
    logic [TLP_W-1:0] mtlp;
    int               mvc;
    bit               mdrop;

    task automatic check(input string tag, input logic [TLP_W-1:0] obs, input logic [TLP_W-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_supported(input logic [4:0] t);
        return (t == 5'd0) || (t == 5'd1) || (t == 5'd10);
    endfunction

    function automatic int m_vc(input logic [2:0] tc);
        return int'(tc) / 4;
    endfunction

    function automatic bit m_ready();
        if (!m_supported(req_type_i)) return 1'b1;
        return mq[m_vc(req_tc_i)].size() < DEPTH;
    endfunction

    function automatic logic [N_VC-1:0] m_full();
        logic [N_VC-1:0] f;
        for (int v = 0; v < N_VC; v++) f[v] = (mq[v].size() == DEPTH);
        return f;
    endfunction

    task automatic m_reset();
        for (int v = 0; v < N_VC; v++) begin
            mq[v].delete();
            mcred[v] = CREDIT_INIT;
        end
        mptr = 0; mvalid = 0; mtlp = '0; mvc = 0; mdrop = 0;
    endtask

    // One clock of the reference model, using the inputs applied for this cycle
    task automatic m_step();
        logic [31:0] d0, d1, d2;
        bit acc;
        int g;
        acc = req_valid_i && m_ready() && m_supported(req_type_i);
        d0 = (32'(req_fmt_i) << 29) | (32'(req_type_i) << 24) | (32'(req_tc_i) << 21) | (32'(req_length_i) << 11);
        if (req_type_i == 5'd10) d1 = 32'(req_completer_id_i) * 65536 + 32'(req_requester_id_i);
        else                     d1 = 32'(req_requester_id_i) * 65536;
        d2 = req_addr_i & 32'hFFFF_FFFC;
        g = -1;
        if (!mvalid || tlp_ready_i) begin
`ifdef URP_PCIE_TX_VC_STRICT_PRIO_EN
            for (int v = N_VC - 1; v >= 0 && g < 0; v--)
                if (mq[v].size() > 0 && mcred[v] > 0) g = v;
`else
            for (int k = 0; k < N_VC && g < 0; k++)
                if (mq[(mptr + k) % N_VC].size() > 0 && mcred[(mptr + k) % N_VC] > 0) g = (mptr + k) % N_VC;
`endif
        end
        if (g >= 0) begin
            mtlp = mq[g].pop_front();
            mvc = g; mvalid = 1; mcred[g]--; mptr = (g + 1) % N_VC;
        end else if (tlp_ready_i) begin
            mvalid = 0;
        end
        for (int v = 0; v < N_VC; v++)
            if (credit_ret_i[v] && mcred[v] < CREDIT_MAX) mcred[v]++;
        if (acc) mq[m_vc(req_tc_i)].push_back({d0, d1, d2, req_payload_i});
        mdrop = req_valid_i && !m_supported(req_type_i);
    endtask

    // Called just after inputs are set near the falling edge
    task automatic tick();
        #1;
        check("req_ready", TLP_W'(req_ready_o), TLP_W'(m_ready()));
        check("vc_full", TLP_W'(vc_full_o), TLP_W'(m_full()));
        check("tlp_valid", TLP_W'(tlp_valid_o), TLP_W'(mvalid));
        check("drop", TLP_W'(drop_o), TLP_W'(mdrop));
        if (mvalid) begin
            check("tlp", tlp_o, mtlp);
            check("tlp_vc", TLP_W'(tlp_vc_o), TLP_W'(mvc));
        end
        if (tlp_valid_o && tlp_ready_i && tlp_vc_o == 1'b1) issued_vc1++;
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic set_req(input bit valid, input logic [4:0] typ, input logic [2:0] tc);
        req_valid_i        = valid;
        req_type_i         = typ;
        req_tc_i           = tc;
        req_fmt_i          = 3'($urandom);
        req_length_i       = 10'($urandom);
        req_requester_id_i = 16'($urandom);
        req_completer_id_i = 16'($urandom);
        req_addr_i         = $urandom;
        req_payload_i      = PAYLOAD_W'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_req(0, 5'd0, 3'd0);
            tick();
        end
    endtask

    function automatic logic [4:0] rand_type();
        logic [4:0] t;
        case ($urandom_range(0, 3))
            0: t = 5'd0;
            1: t = 5'd1;
            2: t = 5'd10;
            default: begin
                t = 5'($urandom);
                while (m_supported(t)) t = 5'($urandom);
            end
        endcase
        return t;
    endfunction

    initial begin
        rst_n = 1'b0;
        credit_ret_i = '0;
        tlp_ready_i = 1'b1;
        set_req(0, 5'd0, 3'd0);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_tlp", tlp_o, '0);
        check("reset_valid", TLP_W'(tlp_valid_o), '0);
        check("reset_vc", TLP_W'(tlp_vc_o), '0);
        check("reset_drop", TLP_W'(drop_o), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single MEM write: visible two cycles after accept with aligned address
        set_req(1, 5'd0, 3'd0);
        req_addr_i = 32'h1234_5678;
        tick();
        idle(1);
        #1;
        check("lat_valid", TLP_W'(tlp_valid_o), TLP_W'(1));
        check("lat_dw2", TLP_W'(tlp_o[PAYLOAD_W +: 32]), TLP_W'(32'h1234_5678));
        check("lat_vc", TLP_W'(tlp_vc_o), '0);
        idle(2);

        // Credit exhaustion on VC1 then a single credit return
        issued_vc1 = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 5'd1, 3'd7);
            tick();
        end
        idle(8);
        check("credit_limit", TLP_W'(issued_vc1), TLP_W'(2));
        set_req(0, 5'd0, 3'd0);
        credit_ret_i = 2'b10;
        tick();
        credit_ret_i = '0;
        idle(6);
        check("credit_return", TLP_W'(issued_vc1), TLP_W'(3));
        credit_ret_i = 2'b11;
        idle(16);
        credit_ret_i = '0;

        // Interleaved queues on both VCs, then drain under continuous ready
        tlp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(1, 5'd0, 3'd0); tick();
            set_req(1, 5'd10, 3'd7); tick();
        end
        tlp_ready_i = 1'b1;
        idle(12);

        // Fill VC0 while stalled; VC1 still accepts
        tlp_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(1, 5'd0, 3'd0); tick();
        end
        set_req(1, 5'd0, 3'd4); tick();
        idle(3);
        tlp_ready_i = 1'b1;
        credit_ret_i = 2'b11;
        idle(12);
        credit_ret_i = '0;

        // Unsupported type is dropped
        set_req(1, 5'b00100, 3'd0); tick();
        idle(3);

        // Hold under back-pressure then reset mid-stream
        for (int i = 0; i < 4; i++) begin
            set_req(1, 5'd0, 3'(i * 2)); tick();
        end
        tlp_ready_i = 1'b0;
        idle(3);
        rst_n = 1'b0;
        m_reset();
        #1;
        check("mid_reset_valid", TLP_W'(tlp_valid_o), '0);
        check("mid_reset_full", TLP_W'(vc_full_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        tlp_ready_i = 1'b1;
        idle(4);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            set_req($urandom_range(0, 9) < 6, rand_type(), 3'($urandom));
            credit_ret_i = N_VC'($urandom) & N_VC'($urandom);
            tlp_ready_i  = $urandom_range(0, 9) < 7;
            tick();
        end
        credit_ret_i = '0;
        tlp_ready_i = 1'b1;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
